// File: rtl/state_log_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | state_log_reader : snapshots four logged states and streams a byte frame   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module state_log_reader #(
   parameter int bits = 8
) (
   input  logic            iClk,
   input  logic            iRst_n,
   input  logic [bits-1:0] iCurrentState,
   input  logic [bits-1:0] iPrevState2,
   input  logic [bits-1:0] iPrevState1,
   input  logic [bits-1:0] iPrevState,
   input  logic            iChange,
   input  logic            iReadReq,
   input  logic            iClearAfterRead,
   input  logic            iAbort,
   input  logic            iReady,
   output logic [7:0]      oData,
   output logic            oValid,
   output logic            oBusy,
   output logic            oDone,
   output logic            oClear_n
);
   localparam int         NB        = (bits + 7) / 8;
   localparam int         FRAME_LEN = 1 + 4 * NB;
   localparam int         FW        = FRAME_LEN * 8;
   localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_idx, w_idx_nxt;
   logic [bits-1:0] r_cur, r_p2, r_p1, r_p;
   logic            r_chg, r_clr;
   logic            w_load, w_valid_nxt, w_done_nxt, w_clear_n_nxt;
   logic [bits-1:0] w_cur, w_p2, w_p1, w_p;
   logic            w_chg;
   logic [FW-1:0]   w_frame;
   logic [7:0]      w_byte;

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_load        = 1'b0;
      w_valid_nxt   = 1'b0;
      w_done_nxt    = 1'b0;
      w_clear_n_nxt = 1'b1;
      case (r_state)
         IDLE: begin
            if (iReadReq) begin
               w_load      = 1'b1;
               w_idx_nxt   = 4'd0;
               w_state_nxt = SEND;
               w_valid_nxt = 1'b1;
            end
         end
         SEND: begin
            // Abort wins over both the accept and the hand-off into CLEAR
            if (iAbort) begin
               w_state_nxt = IDLE;
            end else if (iReady) begin
               if (r_idx == LAST_IDX) begin
                  w_done_nxt = 1'b1;
                  if (r_clr) begin
                     w_state_nxt   = CLEAR;
                     w_clear_n_nxt = 1'b0;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_idx_nxt   = r_idx + 4'd1;
                  w_valid_nxt = 1'b1;
               end
            end else begin
               w_valid_nxt = 1'b1;
            end
         end
         CLEAR:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are registered, so the byte presented next cycle is taken from
   // the snapshot as it will be after this edge.
   assign w_cur = w_load ? iCurrentState : r_cur;
   assign w_p2  = w_load ? iPrevState2   : r_p2;
   assign w_p1  = w_load ? iPrevState1   : r_p1;
   assign w_p   = w_load ? iPrevState    : r_p;
   assign w_chg = w_load ? iChange       : r_chg;

   always_comb begin
      w_frame                         = '0;
      w_frame[7:0]                    = {4'hA, 3'b000, w_chg};
      w_frame[8 +: bits]              = w_cur;
      w_frame[8 + NB * 8 +: bits]     = w_p2;
      w_frame[8 + 2 * NB * 8 +: bits] = w_p1;
      w_frame[8 + 3 * NB * 8 +: bits] = w_p;
   end

   always_comb begin
      w_byte = 8'h00;
      for (int k = 0; k < FRAME_LEN; k++) begin
         if (w_idx_nxt == 4'(k)) w_byte = w_frame[k*8 +: 8];
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         r_state  <= IDLE;
         r_idx    <= 4'd0;
         r_cur    <= '0;
         r_p2     <= '0;
         r_p1     <= '0;
         r_p      <= '0;
         r_chg    <= 1'b0;
         r_clr    <= 1'b0;
         oData    <= 8'h00;
         oValid   <= 1'b0;
         oBusy    <= 1'b0;
         oDone    <= 1'b0;
         oClear_n <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_load) begin
            r_cur <= iCurrentState;
            r_p2  <= iPrevState2;
            r_p1  <= iPrevState1;
            r_p   <= iPrevState;
            r_chg <= iChange;
            r_clr <= iClearAfterRead;
         end
         oData    <= w_valid_nxt ? w_byte : 8'h00;
         oValid   <= w_valid_nxt;
         oBusy    <= (w_state_nxt != IDLE);
         oDone    <= w_done_nxt;
         oClear_n <= w_clear_n_nxt;
      end
   end
endmodule
`default_nettype wire
